mxu_operand_loader: RTL and testbench

//   Upstream feeder for temporal_mxu. Accepts one DIM-element operand row per handshake:
//   DIM rows of A, then DIM rows of B. Holds both matrices in registers and pulses start.

---
 rtl/mxu_pkg.sv | 8 +
 rtl/mxu_operand_loader.sv | 55 +++++
 tb/tb_mxu_operand_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mxu_pkg.sv
// mxu_pkg: shared operand row/matrix types and loader FSM states for the MXU datapath
package mxu_pkg;
  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_DIM = 16;
  typedef logic [DEF_DIM-1:0][DEF_BIT_WIDTH-1:0] row_t;
  typedef row_t [DEF_DIM-1:0] matrix_t;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, FIRE, WAIT} loader_state_t;
endpackage

// File: rtl/mxu_operand_loader.sv
// mxu_operand_loader: gathers A then B row by row, fires temporal_mxu, holds operands until done
module mxu_operand_loader
  import mxu_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int DIM = DEF_DIM
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DIM-1:0][BIT_WIDTH-1:0]          in_row,
  input  logic                                   mxu_done,
  output logic                                   start,
  output logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0] A,
  output logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0] B,
  output logic                                   busy,
  output logic [15:0]                            jobs_done
);
  localparam int CW = $clog2(DIM);
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);
  loader_state_t state, state_n;
  logic [CW-1:0] row_cnt;
  logic xfer, last;
  assign in_ready = state == LOAD_A || state == LOAD_B;
  assign start = state == FIRE;
  assign xfer = in_valid && in_ready;
  assign last = xfer && row_cnt == LAST;
  always_comb begin
    state_n = state == LOAD_A ? (last ? LOAD_B : LOAD_A) :
              state == LOAD_B ? (last ? FIRE : LOAD_B) :
              state == FIRE   ? WAIT :
              mxu_done        ? LOAD_A : WAIT;
  end
  // busy mirrors the next state so it is already high during the start cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD_A;
      row_cnt   <= '0;
      A         <= '0;
      B         <= '0;
      busy      <= 1'b0;
      jobs_done <= '0;
    end else begin
      state <= state_n;
      busy  <= state_n == FIRE || state_n == WAIT;
      if (xfer) begin
        row_cnt <= last ? '0 : row_cnt + 1'b1;
        if (state == LOAD_A) A[row_cnt] <= in_row;
        else B[row_cnt] <= in_row;
      end
      if (state == WAIT && mxu_done) jobs_done <= jobs_done + 16'd1;
    end
  end
endmodule

// File: tb/tb_mxu_operand_loader.sv
// tb_mxu_operand_loader: directed stimulus against a row-count model of the operand loader
module tb_mxu_operand_loader;
  import mxu_pkg::*;
  localparam int N = DEF_DIM;
  logic clk = 0, reset = 1, in_valid = 0, mxu_done = 0;
  row_t in_row = '0;
  logic in_ready, start, busy;
  matrix_t A, B;
  logic [15:0] jobs_done;
  int checks = 0, failures = 0, starts = 0, s0 = 0;
  matrix_t mA = '0, mB = '0;
  int m_cnt = 0, m_jobs = 0;
  bit m_fire = 0, m_busy = 0, live = 0;

  always #5 clk = ~clk;

  mxu_operand_loader #(.BIT_WIDTH(DEF_BIT_WIDTH), .DIM(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .mxu_done(mxu_done), .start(start), .A(A), .B(B), .busy(busy), .jobs_done(jobs_done)
  );

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_mat(string name, matrix_t got, matrix_t exp);
    int bad = -1;
    checks++;
    if (got !== exp) begin
      failures++;
      for (int r = N - 1; r >= 0; r--) if (got[r] !== exp[r]) bad = r;
      $display("FAIL %s: row %0d got %h expected %h", name, bad, got[bad], exp[bad]);
    end
  endtask

  // Model: a job is 2*N accepted rows, then one start cycle, then waiting for done
  always @(posedge clk) begin
    if (reset) begin
      mA <= '0; mB <= '0; m_cnt <= 0; m_fire <= 0; m_busy <= 0; m_jobs <= 0;
    end else if (m_cnt < 2 * N) begin
      if (in_valid) begin
        if (m_cnt < N) mA[m_cnt] <= in_row;
        else mB[m_cnt-N] <= in_row;
        m_cnt <= m_cnt + 1;
        if (m_cnt == 2 * N - 1) begin
          m_fire <= 1; m_busy <= 1;
        end
      end
    end else if (m_fire) m_fire <= 0;
    else if (mxu_done) begin
      m_busy <= 0; m_jobs <= m_jobs + 1; m_cnt <= 0;
    end
    live <= 1;
  end

  always @(negedge clk) if (live) begin
    chk("in_ready", in_ready, m_cnt < 2 * N);
    chk("start", start, m_fire);
    chk("busy", busy, m_busy);
    chk("jobs_done", jobs_done, 16'(m_jobs));
    chk_mat("A", A, mA);
    chk_mat("B", B, mB);
    if (start) starts++;
  end

  function automatic row_t row_a(int r);
    row_t x;
    for (int c = 0; c < N; c++) x[c] = 8'((r + c + 1) % 4);
    return x;
  endfunction

  function automatic row_t row_b(int r);
    row_t x;
    for (int c = 0; c < N; c++) x[c] = 8'(c % 4);
    return x;
  endfunction

  function automatic row_t row_c(int r);
    row_t x;
    for (int c = 0; c < N; c++) x[c] = 8'(r * 16 + c);
    return x;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(row_t r, bit gaps);
    int n = 0;
    bit ok = 0;
    if (gaps) while ($urandom_range(1) == 1) cyc();
    in_valid = 1;
    in_row = r;
    do begin
      ok = in_ready;
      cyc();
      n++;
    end while (!ok && n < 200);
    chk("handshake", ok, 1);
    in_valid = 0;
  endtask

  task automatic load(bit pat_c, bit gaps);
    for (int r = 0; r < N; r++) send(pat_c ? row_c(r) : row_a(r), gaps);
    for (int r = 0; r < N; r++) send(row_b(r), gaps);
  endtask

  task automatic to_wait();
    int n = 0;
    while (!(busy && !start) && n < 300) begin
      cyc();
      n++;
    end
    chk("reach_wait", busy && !start, 1);
  endtask

  task automatic finish_job(int hold);
    to_wait();
    repeat (3) cyc();
    mxu_done = 1;
    repeat (hold) cyc();
    mxu_done = 0;
    cyc();
  endtask

  initial begin
    repeat (2) cyc();
    reset = 0;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_jobs", jobs_done, 0);
    chk_mat("rst_A", A, '0);
    // back-to-back job
    s0 = starts;
    load(0, 0);
    chk("start_after_last", start, 1);
    cyc();
    chk("start_one_cycle", start, 0);
    chk("ready_low_wait", in_ready, 0);
    chk("A00", A[0][0], 8'd1);
    chk("model_A00", mA[0][0], 8'd1);
    chk("A1515", A[15][15], 8'd3);
    chk("model_A1515", mA[15][15], 8'd3);
    chk("B37", B[3][7], 8'd3);
    finish_job(1);
    chk("one_start_job1", starts - s0, 1);
    chk("jobs_1", jobs_done, 1);
    // gapped load, then in_valid held during WAIT
    s0 = starts;
    load(0, 1);
    to_wait();
    in_valid = 1;
    in_row = {N{8'hAA}};
    repeat (4) cyc();
    chk("ready_held_wait", in_ready, 0);
    chk("A00_held", A[0][0], 8'd1);
    mxu_done = 1;
    cyc();
    mxu_done = 0;
    cyc();
    in_valid = 0;
    chk("one_start_job2", starts - s0, 1);
    chk("A0_after_done", A[0], {N{8'hAA}});
    chk("jobs_2", jobs_done, 2);
    // done pulse while loading B is ignored
    for (int r = 1; r < N; r++) send(row_a(r), 0);
    for (int r = 0; r < 5; r++) send(row_b(r), 0);
    mxu_done = 1;
    cyc();
    mxu_done = 0;
    chk("jobs_ignore", jobs_done, 2);
    chk("ready_ignore", in_ready, 1);
    send({N{8'h55}}, 0);
    chk("B5_lands", B[5], {N{8'h55}});
    for (int r = 6; r < N; r++) send(row_b(r), 0);
    finish_job(1);
    chk("jobs_3", jobs_done, 3);
    // reset mid-load
    for (int r = 0; r < 20; r++) send(r < N ? row_c(r) : row_b(r - N), 0);
    reset = 1;
    cyc();
    reset = 0;
    chk_mat("midrst_A", A, '0);
    chk_mat("midrst_B", B, '0);
    chk("midrst_start", start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_jobs", jobs_done, 0);
    load(1, 0);
    chk("fresh_A00", A[0][0], 8'h00);
    chk("fresh_A10", A[1][0], 8'h10);
    chk("fresh_A1515", A[15][15], 8'hff);
    finish_job(1);
    // two jobs with a held done
    reset = 1;
    cyc();
    reset = 0;
    s0 = starts;
    load(0, 0);
    finish_job(3);
    for (int r = 0; r < N; r++) send(row_c(r), 0);
    for (int r = 0; r < N - 1; r++) send(row_b(r), 0);
    chk("no_early_start", starts - s0, 1);
    send(row_b(N - 1), 0);
    chk("second_start", start, 1);
    finish_job(3);
    chk("two_starts", starts - s0, 2);
    chk("jobs_held_done", jobs_done, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
